// File: rtl/ram_stream_reader.sv
// Burst read controller: issues sequential RAM reads from a base address and
// presents the returned words as a valid/ready stream through a 2-entry buffer.
module ram_stream_reader #(
   parameter int addressWidth = 16,
   parameter int dataWidth    = 16,
   parameter int lenWidth     = 17
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic        [addressWidth-1:0] base_addr,
   input  logic        [lenWidth-1:0]     length,
   output logic                           busy,
   output logic                           done,
   output logic        [addressWidth-1:0] mem_address,
   output logic                           mem_rd_wrn,
   output logic signed [dataWidth-1:0]    mem_data_in,
   input  logic signed [dataWidth-1:0]    mem_data_out,
   output logic signed [dataWidth-1:0]    out_data,
   output logic                           out_valid,
   input  logic                           out_ready
);

   typedef enum logic [1:0] {IDLE, READ, FINISH} state_t;

   state_t                         state_q, state_d;
   logic        [addressWidth-1:0] addr_q, addr_d;
   logic        [lenWidth-1:0]     len_q, len_d;
   logic        [lenWidth-1:0]     issued_q, issued_d;
   logic        [lenWidth-1:0]     popped_q, popped_d;
   logic                           rd_pending_q, rd_pending_d;
   logic        [1:0]              cnt_q, cnt_d;
   logic signed [dataWidth-1:0]    buf0_q, buf0_d;
   logic signed [dataWidth-1:0]    buf1_q, buf1_d;

   logic       pop, push, start_ok, room, issue, last_pop;
   logic [2:0] occ;

   assign out_valid   = (cnt_q != 2'd0);
   assign out_data    = buf0_q;
   assign mem_address = addr_q;
   assign mem_rd_wrn  = 1'b1;
   assign mem_data_in = '0;

   assign pop      = out_valid && out_ready;
   assign push     = rd_pending_q;
   assign start_ok = (state_q == IDLE) && start;
   // Words already buffered or in flight; a pop this edge frees one slot.
   assign occ      = {1'b0, cnt_q} + {2'b00, rd_pending_q};
   assign room     = pop ? (occ < 3'd3) : (occ < 3'd2);
   assign issue    = (state_q == READ) && (issued_q < len_q) && room;
   assign last_pop = pop && ((popped_q + lenWidth'(1)) == len_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         issued_q     <= '0;
         popped_q     <= '0;
         rd_pending_q <= 1'b0;
         cnt_q        <= 2'd0;
         buf0_q       <= '0;
         buf1_q       <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         issued_q     <= issued_d;
         popped_q     <= popped_d;
         rd_pending_q <= rd_pending_d;
         cnt_q        <= cnt_d;
         buf0_q       <= buf0_d;
         buf1_q       <= buf1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (length == '0) ? FINISH : READ;
         READ:    if (last_pop) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == READ);
      done = (state_q == FINISH);
   end

   always_comb begin
      addr_d       = addr_q;
      len_d        = len_q;
      issued_d     = issued_q;
      popped_d     = popped_q;
      rd_pending_d = issue;
      cnt_d        = cnt_q;
      buf0_d       = buf0_q;
      buf1_d       = buf1_q;

      if (start_ok) begin
         addr_d   = base_addr;
         len_d    = length;
         issued_d = '0;
         popped_d = '0;
      end
      if (issue) begin
         issued_d = issued_q + lenWidth'(1);
         addr_d   = addr_q + addressWidth'(1);
      end
      if (pop) popped_d = popped_q + lenWidth'(1);

      // Buffer is a 2-deep shift queue with buf0 as the head.
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) buf0_d = mem_data_out;
            else               buf1_d = mem_data_out;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               buf0_d = mem_data_out;
            end else begin
               buf0_d = buf1_q;
               buf1_d = mem_data_out;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a registered-read RAM model holding mem[a] = 3*a.
module tb_ram_stream_reader;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic        [15:0] base_addr = '0;
   logic        [16:0] length = '0;
   logic               busy, done, mem_rd_wrn, out_valid;
   logic        [15:0] mem_address;
   logic signed [15:0] mem_data_in, out_data;
   logic signed [15:0] mem_data_out = '0;
   logic               out_ready = 1'b0;

   logic [15:0] mem [0:65535];
   int vectors = 0;
   int miscompares = 0;

   ram_stream_reader dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .mem_address(mem_address), .mem_rd_wrn(mem_rd_wrn),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) mem_data_out <= mem[mem_address];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] word_at(input logic [15:0] a);
      return 16'(32'(a) * 3);
   endfunction

   task automatic test_reset();
      #3;
      vectors++;
      if ({busy, done, out_valid} !== 3'b000) begin
         miscompares++; $display("FAIL reset_ctl: got %b expected 000", {busy, done, out_valid});
      end
      vectors++;
      if (out_data !== 16'sd0 || mem_address !== 16'h0000) begin
         miscompares++; $display("FAIL reset_data: got %h/%h expected 0000/0000", out_data, mem_address);
      end
      vectors++;
      if (mem_rd_wrn !== 1'b1 || mem_data_in !== 16'sd0) begin
         miscompares++; $display("FAIL mem_ctl: got %b/%h expected 1/0000", mem_rd_wrn, mem_data_in);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_streaming();
      logic [15:0] exp_w [4];
      exp_w[0] = 16'h0030; exp_w[1] = 16'h0033; exp_w[2] = 16'h0036; exp_w[3] = 16'h0039;
      start = 1'b1; base_addr = 16'h0010; length = 17'd4; out_ready = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || mem_address !== 16'h0010 || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL stream_e0: got busy=%b addr=%h vld=%b expected 1/0010/0", busy, mem_address, out_valid);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL stream_e1_valid: got %b expected 0", out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
            miscompares++; $display("FAIL stream_word%0d: got vld=%b %h expected 1 %h", i, out_valid, out_data, exp_w[i]);
         end
      end
      tick();
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL stream_done: got done=%b busy=%b vld=%b expected 1/0/0", done, busy, out_valid);
      end
      tick();
      vectors++;
      if (done !== 1'b0) begin
         miscompares++; $display("FAIL stream_done_pulse: got %b expected 0", done);
      end
      out_ready = 1'b0;
   endtask

   // Generic burst: optional back-pressure pattern and optional start injected mid-burst.
   task automatic run_burst(input logic [15:0] b, input int n, input bit bp, input bit inj);
      logic [7:0]  pat = 8'b1110_1001;
      logic [15:0] held = '0;
      logic [15:0] iss;
      logic        stalled = 1'b0;
      int          pops = 0;
      int          dones = 0;
      start = 1'b1; base_addr = b; length = 17'(n); out_ready = 1'b0;
      tick();
      start = 1'b0;
      for (int c = 0; c < 300 && dones == 0; c++) begin
         if (done) begin
            dones++;
         end else begin
            if (out_valid && stalled) begin
               vectors++;
               if (out_data !== held) begin
                  miscompares++; $display("FAIL hold_b%h: got %h expected %h", b, out_data, held);
               end
            end
            iss = mem_address - b;
            if (int'(iss) > pops + 2) begin
               vectors++; miscompares++;
               $display("FAIL outstanding_b%h: got %0d issued %0d popped expected <= +2", b, iss, pops);
            end
            start = inj && (c == 2);
            if (start) begin base_addr = 16'h0100; length = 17'd5; end
            out_ready = bp ? pat[c % 8] : 1'b1;
            if (out_valid && out_ready) begin
               vectors++;
               if (out_data !== word_at(b + 16'(pops))) begin
                  miscompares++;
                  $display("FAIL word_b%h_%0d: got %h expected %h", b, pops, out_data, word_at(b + 16'(pops)));
               end
               pops++;
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            tick();
         end
      end
      start = 1'b0;
      vectors++;
      if (dones != 1 || pops != n) begin
         miscompares++; $display("FAIL burst_end_b%h: got done=%0d words=%0d expected 1 %0d", b, dones, pops, n);
      end
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL burst_idle_b%h: got busy=%b vld=%b expected 0/0", b, busy, out_valid);
      end
      tick();
      vectors++;
      if (done !== 1'b0) begin
         miscompares++; $display("FAIL burst_done_pulse_b%h: got %b expected 0", b, done);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back_bp();
      run_burst(16'h0010, 8, 1'b1, 1'b0);
   endtask

   task automatic test_zero_length();
      start = 1'b1; base_addr = 16'h0005; length = 17'd0; out_ready = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL zero_len: got done=%b busy=%b vld=%b expected 1/0/0", done, busy, out_valid);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL zero_len_after: got done=%b busy=%b vld=%b expected 0/0/0", done, busy, out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      run_burst(16'hFFFE, 4, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midburst();
      int pops = 0;
      start = 1'b1; base_addr = 16'h0000; length = 17'd6; out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 20 && pops < 2; c++) begin
         tick();
         if (out_valid) pops++;
      end
      tick();
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || mem_address !== 16'h0000 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got busy=%b vld=%b addr=%h done=%b expected 0/0/0000/0", busy, out_valid, mem_address, done);
      end
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      tick();
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL post_reset_idle: got busy=%b vld=%b expected 0/0", busy, out_valid);
      end
      run_burst(16'h0000, 2, 1'b0, 1'b0);
   endtask

   task automatic test_start_handling();
      int dones = 0;
      run_burst(16'h0020, 3, 1'b1, 1'b1);
      // Start held through the done cycle is accepted only once back in IDLE.
      start = 1'b1; base_addr = 16'h0007; length = 17'd0;
      tick();
      base_addr = 16'h0040; length = 17'd2;
      vectors++;
      if (done !== 1'b1) begin
         miscompares++; $display("FAIL held_start_done: got %b expected 1", done);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("FAIL held_start_finish: got busy=%b done=%b expected 0/0", busy, done);
      end
      tick();
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || mem_address !== 16'h0040) begin
         miscompares++; $display("FAIL held_start_accept: got busy=%b addr=%h expected 1/0040", busy, mem_address);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 40 && dones == 0; c++) begin
         tick();
         if (done) dones++;
      end
      vectors++;
      if (dones != 1) begin
         miscompares++; $display("FAIL held_start_complete: got %0d expected 1", dones);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = word_at(16'(a));
      test_reset();
      test_streaming();
      test_back_to_back_bp();
      test_zero_length();
      test_wrap();
      test_reset_midburst();
      test_start_handling();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side controller for the single-port weight/activation RAM used by the BNN layers.
- On a start pulse it issues sequential reads from base_addr for length words.
- It absorbs the RAM's one-cycle registered read latency and presents the words as a valid/ready stream to the downstream compute unit.
- A 2-entry output buffer sustains one word per cycle under back-pressure without losing or duplicating data.

Parameters:
- addressWidth, 16, width of RAM address and base_addr.
- dataWidth, 16, width of a RAM word, signed.
- lenWidth, 17, width of length; addressWidth+1 allows a full-memory burst.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- base_addr  input  addressWidth  first address of the burst; latched on accepted start.
- length  input  lenWidth  number of words; latched on accepted start.
- busy  output  1  high while a burst is active.
- done  output  1  one-cycle pulse at burst completion.
- mem_address  output  addressWidth  registered RAM address.
- mem_rd_wrn  output  1  RAM direction; constant 1 (read).
- mem_data_in  output  dataWidth  RAM write data; constant 0.
- mem_data_out  input  dataWidth  registered RAM read data, valid the cycle after an address is sampled.
- out_data  output  dataWidth  signed stream word (buffer head).
- out_valid  output  1  stream valid.
- out_ready  input  1  downstream accept; a word transfers on a rising edge with out_valid=1 and out_ready=1 (pop).

Behaviour:
- Reset (reset=0, asynchronous):
  - State becomes IDLE; busy, done, out_valid, out_data, mem_address, buffer count, issue count, pop count and rd_pending all go to 0.
  - Any in-flight data is discarded; RAM contents are untouched.
- States:
  - IDLE -> READ on an edge with start=1 and length>0.
  - IDLE -> FINISH on an edge with start=1 and length=0.
  - READ -> FINISH on the edge of the final pop.
  - FINISH -> IDLE unconditionally after one cycle.
- busy is 1 in READ only. done is 1 in FINISH only.
- start is ignored in READ and FINISH.
- start in the same cycle as done is not accepted (FINISH ignores it); it must be re-presented in IDLE.
- On an accepted start: latch length, and set mem_address = base_addr.
- The RAM reads on every edge. mem_rd_wrn is never 0, so the block can never corrupt memory.
- Issue rule: an issue occurs on an edge in READ when both hold:
  - issued < length;
  - buf_count + rd_pending - pop < 2, where pop is 1 if a pop happens on that edge.
- On an issue: issued increments, mem_address increments modulo 2^addressWidth, and rd_pending is set to 1 for the next cycle. Otherwise rd_pending is 0.
- Non-issued address presentations produce don't-care reads and are never pushed.
- When rd_pending=1, mem_data_out is pushed into the buffer tail on the next edge.
- Push and pop on the same edge are legal and leave the count unchanged.
- The buffer never exceeds 2 entries and never overflows.
- out_valid = (buf_count > 0). out_data is the buffer head and holds while out_valid=1 and out_ready=0.
- Latency: with start accepted at edge E0 and out_ready=1:
  - RAM samples base at E1;
  - push at E2, so out_valid=1 in the cycle after E2;
  - one word per cycle after that.
- Final pop at edge Ef: done=1 and busy=0 in the cycle after Ef.
- Words are delivered strictly in address order, exactly length words, no duplicates.
- Address wrap: base_addr+i is taken modulo 2^addressWidth.

Test Plan:
- Streaming: mem[a]=3*a, base=0x0010, length=4, out_ready=1 -> out_valid first high in the cycle after the second edge past start; out_data 0x0030, 0x0033, 0x0036, 0x0039 on consecutive cycles; done pulse once, the cycle after the last pop.
- Back-pressure: same burst with length=8, out_ready=1,0,0,1,0,1,1,1,... -> all 8 words in order, no drop or duplicate; out_data stable while stalled; issued minus popped never exceeds 2.
- Zero length: start with length=0 -> done=1 the next cycle; out_valid never asserts; busy stays 0.
- Wrap: addressWidth=4, memDepth=16, base=14, length=4 -> addresses 14, 15, 0, 1 in order; data mem[14], mem[15], mem[0], mem[1].
- Reset mid-burst: drop reset to 0 after 2 of 6 words -> busy, out_valid and mem_address go to 0 immediately without a clock; after release, a new start (base=0, length=2) delivers mem[0], mem[1] correctly.
- Start handling: a start during READ is ignored and the current burst is unchanged; a start held through the done cycle is accepted on the first IDLE edge.
